// File: rtl/matrix_cmd_seq.sv
// Command sequencer for a modelview/projection matrix stack: decodes command beats
// into load, load-identity and pop strobes, and streams four 128-bit rows into the stack.
module matrix_cmd_seq #(
    parameter int MV_DEPTH = 32,
    parameter int PJ_DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [127:0] cmd_data,
    input  logic [127:0] peek_in_0,
    input  logic [127:0] peek_in_1,
    input  logic [127:0] peek_in_2,
    input  logic [127:0] peek_in_3,
    output logic         matrix_mode,
    output logic         load_en,
    output logic         load_id_en,
    output logic         pop_en,
    output logic [127:0] data_out,
    output logic         err_pulse,
    output logic         err_ovf,
    output logic         err_unf,
    output logic         busy
);

    // state   | meaning
    // IDLE    | decode single-beat commands
    // COLLECT | gathering LOAD rows 1..3
    // POPISS  | pop the old top before reloading it
    // STREAM  | emit rows 0..3 with load_en on row 0
    typedef enum logic [1:0] {IDLE, COLLECT, POPISS, STREAM} state_t;

    localparam logic [2:0] OP_MODE    = 3'd1;
    localparam logic [2:0] OP_LOAD_ID = 3'd2;
    localparam logic [2:0] OP_LOAD    = 3'd3;
    localparam logic [2:0] OP_PUSH    = 3'd4;
    localparam logic [2:0] OP_POP     = 3'd5;

    state_t       state, state_next;
    logic [1:0]   row, row_next;
    logic [127:0] rows [4];
    logic [5:0]   mv_depth, pj_depth;
    logic [5:0]   cur_depth, cur_cap;
    logic         accept;
    logic         pop_q;
    logic         push_ok, push_ovf, pop_ok, pop_unf, mode_set, load_id_set, load_first;

    assign cmd_ready = !rst && (state == IDLE || state == COLLECT);
    assign accept    = cmd_valid && cmd_ready;
    assign cur_depth = matrix_mode ? pj_depth : mv_depth;
    assign cur_cap   = matrix_mode ? 6'(PJ_DEPTH) : 6'(MV_DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            row   <= 2'd0;
        end else begin
            state <= state_next;
            row   <= row_next;
        end
    end

    always_comb begin
        state_next  = state;
        row_next    = row;
        push_ok     = 1'b0;
        push_ovf    = 1'b0;
        pop_ok      = 1'b0;
        pop_unf     = 1'b0;
        mode_set    = 1'b0;
        load_id_set = 1'b0;
        load_first  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_MODE:    mode_set = 1'b1;
                        OP_LOAD_ID: load_id_set = 1'b1;
                        OP_LOAD: begin
                            load_first = 1'b1;
                            state_next = COLLECT;
                            row_next   = 2'd1;
                        end
                        OP_PUSH: begin
                            if (cur_depth < cur_cap) begin
                                push_ok    = 1'b1;
                                state_next = STREAM;
                                row_next   = 2'd0;
                            end else begin
                                push_ovf = 1'b1;
                            end
                        end
                        OP_POP: begin
                            if (cur_depth > 6'd1) pop_ok = 1'b1;
                            else                  pop_unf = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            COLLECT: begin
                if (accept) begin
                    row_next = row + 2'd1;
                    if (row == 2'd3) begin
                        state_next = POPISS;
                        row_next   = 2'd0;
                    end
                end
            end
            POPISS: begin
                state_next = STREAM;
                row_next   = 2'd0;
            end
            STREAM: begin
                row_next = row + 2'd1;
                if (row == 2'd3) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Row buffer holds either the PUSH snapshot or the collected LOAD beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) rows[i] <= '0;
        end else if (push_ok) begin
            rows[0] <= peek_in_0;
            rows[1] <= peek_in_1;
            rows[2] <= peek_in_2;
            rows[3] <= peek_in_3;
        end else if (load_first) begin
            rows[0] <= cmd_data;
        end else if (state == COLLECT && accept) begin
            rows[row] <= cmd_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_depth    <= 6'd1;
            pj_depth    <= 6'd1;
            matrix_mode <= 1'b0;
            pop_q       <= 1'b0;
            load_id_en  <= 1'b0;
            err_pulse   <= 1'b0;
            err_ovf     <= 1'b0;
            err_unf     <= 1'b0;
        end else begin
            pop_q      <= pop_ok;
            load_id_en <= load_id_set;
            err_pulse  <= push_ovf || pop_unf;
            if (push_ovf) err_ovf <= 1'b1;
            if (pop_unf)  err_unf <= 1'b1;
            if (mode_set) matrix_mode <= cmd_data[0];
            if (push_ok) begin
                if (matrix_mode) pj_depth <= pj_depth + 6'd1;
                else             mv_depth <= mv_depth + 6'd1;
            end else if (pop_ok) begin
                if (matrix_mode) pj_depth <= pj_depth - 6'd1;
                else             mv_depth <= mv_depth - 6'd1;
            end
        end
    end

    assign load_en  = (state == STREAM) && (row == 2'd0);
    assign pop_en   = pop_q || (state == POPISS);
    assign data_out = (state == STREAM) ? rows[row] : '0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_matrix_cmd_seq.sv
// Directed bench for matrix_cmd_seq: a table of single-beat commands followed by
// hand-written PUSH, POP, overflow, LOAD, mid-stream reset and LOAD_ID sequences.
module tb_matrix_cmd_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [2:0]   cmd_op;
    logic [127:0] cmd_data;
    logic [127:0] peek_in_0, peek_in_1, peek_in_2, peek_in_3;
    logic         matrix_mode, load_en, load_id_en, pop_en;
    logic [127:0] data_out;
    logic         err_pulse, err_ovf, err_unf, busy;

    int tests  = 0;
    int failed = 0;

    matrix_cmd_seq #(.MV_DEPTH(32), .PJ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data),
        .peek_in_0(peek_in_0), .peek_in_1(peek_in_1),
        .peek_in_2(peek_in_2), .peek_in_3(peek_in_3),
        .matrix_mode(matrix_mode), .load_en(load_en),
        .load_id_en(load_id_en), .pop_en(pop_en),
        .data_out(data_out), .err_pulse(err_pulse),
        .err_ovf(err_ovf), .err_unf(err_unf), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]   op;
        logic [127:0] data;
        logic         mode;
        logic         lid;
        logic         pop;
        logic         err;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge and check strobe exclusivity there.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("strobe_onehot", 128'(($countones({load_en, load_id_en, pop_en}) <= 1)), 128'd1);
    endtask

    task automatic beat(input logic [2:0] op, input logic [127:0] d);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk("beat_ready_timeout", 128'(cmd_ready), 128'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_data  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        int lid_cnt;
        int rdy_low;
        logic busy_seen;

        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_data = '0;
        peek_in_0 = 128'd1;
        peek_in_1 = 128'd2;
        peek_in_2 = 128'd3;
        peek_in_3 = 128'd4;

        vecs[0] = '{op: 3'd0, data: 128'd0,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[1] = '{op: 3'd6, data: 128'd1,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[2] = '{op: 3'd7, data: 128'd1,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[3] = '{op: 3'd1, data: 128'd1,  mode: 1'b1, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[4] = '{op: 3'd5, data: 128'd0,  mode: 1'b1, lid: 1'b0, pop: 1'b0, err: 1'b1};
        vecs[5] = '{op: 3'd2, data: 128'd0,  mode: 1'b1, lid: 1'b1, pop: 1'b0, err: 1'b0};
        vecs[6] = '{op: 3'd1, data: 128'd2,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[7] = '{op: 3'd5, data: 128'd0,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b1};
        vecs[8] = '{op: 3'd1, data: 128'hFF, mode: 1'b1, lid: 1'b0, pop: 1'b0, err: 1'b0};
        vecs[9] = '{op: 3'd1, data: 128'd0,  mode: 1'b0, lid: 1'b0, pop: 1'b0, err: 1'b0};

        tick();
        chk("rst_ready", 128'(cmd_ready), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_data", data_out, 128'd0);
        chk("rst_mode", 128'(matrix_mode), 128'd0);
        rst = 1'b0;
        #1;
        chk("rel_ready", 128'(cmd_ready), 128'd1);

        for (int i = 0; i < 10; i++) begin
            beat(vecs[i].op, vecs[i].data);
            chk($sformatf("vec%0d_mode", i), 128'(matrix_mode), 128'(vecs[i].mode));
            chk($sformatf("vec%0d_lid", i), 128'(load_id_en), 128'(vecs[i].lid));
            chk($sformatf("vec%0d_pop", i), 128'(pop_en), 128'(vecs[i].pop));
            chk($sformatf("vec%0d_err", i), 128'(err_pulse), 128'(vecs[i].err));
            chk($sformatf("vec%0d_busy", i), 128'(busy), 128'd0);
            chk($sformatf("vec%0d_load", i), 128'(load_en), 128'd0);
            tick();
            chk($sformatf("vec%0d_quiet", i), 128'({load_id_en, pop_en, err_pulse}), 128'd0);
        end

        // PUSH streams the snapshot rows
        do_reset();
        beat(3'd4, '0);
        peek_in_0 = 128'hDEAD;
        chk("push_r0_load", 128'(load_en), 128'd1);
        chk("push_r0_data", data_out, 128'd1);
        chk("push_r0_ready", 128'(cmd_ready), 128'd0);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("push_r%0d_load", k), 128'(load_en), 128'd0);
            chk($sformatf("push_r%0d_data", k), data_out, 128'(k + 1));
        end
        tick();
        chk("push_done_ready", 128'(cmd_ready), 128'd1);
        chk("push_done_busy", 128'(busy), 128'd0);
        chk("push_done_data", data_out, 128'd0);
        chk("push_mv_depth", 128'(dut.mv_depth), 128'd2);
        peek_in_0 = 128'd1;

        // POP succeeds once, then underflows
        beat(3'd5, '0);
        chk("pop1_en", 128'(pop_en), 128'd1);
        chk("pop1_err", 128'(err_pulse), 128'd0);
        tick();
        chk("pop1_once", 128'(pop_en), 128'd0);
        chk("pop1_depth", 128'(dut.mv_depth), 128'd1);
        beat(3'd5, '0);
        chk("pop2_en", 128'(pop_en), 128'd0);
        chk("pop2_err", 128'(err_pulse), 128'd1);
        chk("pop2_unf", 128'(err_unf), 128'd1);
        tick();
        chk("pop2_err_once", 128'(err_pulse), 128'd0);
        chk("pop2_unf_sticky", 128'(err_unf), 128'd1);

        // Projection overflow at capacity 2
        beat(3'd1, 128'd1);
        chk("pj_mode", 128'(matrix_mode), 128'd1);
        beat(3'd4, '0);
        chk("pj_push_load", 128'(load_en), 128'd1);
        for (int k = 0; k < 4; k++) tick();
        chk("pj_push_idle", 128'(busy), 128'd0);
        beat(3'd4, '0);
        chk("ovf_err", 128'(err_pulse), 128'd1);
        chk("ovf_flag", 128'(err_ovf), 128'd1);
        chk("ovf_load", 128'(load_en), 128'd0);
        chk("ovf_busy", 128'(busy), 128'd0);
        tick();
        chk("ovf_load_later", 128'(load_en), 128'd0);
        chk("ovf_pj_depth", 128'(dut.pj_depth), 128'd2);
        chk("ovf_mv_depth", 128'(dut.mv_depth), 128'd1);

        // LOAD with two idle cycles between beats
        beat(3'd1, 128'd0);
        chk("load_mode0", 128'(matrix_mode), 128'd0);
        beat(3'd3, 128'hA);
        chk("load_collect_busy", 128'(busy), 128'd1);
        for (int b = 1; b < 4; b++) begin
            tick();
            tick();
            chk($sformatf("load_gap%0d_quiet", b), 128'({load_en, pop_en}), 128'd0);
            chk($sformatf("load_gap%0d_data", b), data_out, 128'd0);
            chk($sformatf("load_gap%0d_ready", b), 128'(cmd_ready), 128'd1);
            beat(3'(b + 4), 128'hA + 128'(b));
        end
        rdy_low = 0;
        rdy_low += int'(!cmd_ready);
        chk("load_popiss_pop", 128'(pop_en), 128'd1);
        chk("load_popiss_load", 128'(load_en), 128'd0);
        chk("load_popiss_data", data_out, 128'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            rdy_low += int'(!cmd_ready);
            chk($sformatf("load_r%0d_load", k), 128'(load_en), 128'(k == 0));
            chk($sformatf("load_r%0d_pop", k), 128'(pop_en), 128'd0);
            chk($sformatf("load_r%0d_data", k), data_out, 128'hA + 128'(k));
        end
        tick();
        chk("load_done_ready", 128'(cmd_ready), 128'd1);
        chk("load_done_busy", 128'(busy), 128'd0);
        chk("load_ready_low", 128'(rdy_low), 128'd5);
        chk("load_mv_depth", 128'(dut.mv_depth), 128'd1);

        // Reset during the second STREAM row
        beat(3'd4, '0);
        tick();
        chk("rst_mid_data_pre", data_out, 128'd2);
        rst = 1'b1;
        #1;
        chk("rst_mid_strobes", 128'({load_en, load_id_en, pop_en}), 128'd0);
        chk("rst_mid_data", data_out, 128'd0);
        chk("rst_mid_busy", 128'(busy), 128'd0);
        chk("rst_mid_errs", 128'({err_ovf, err_unf}), 128'd0);
        chk("rst_mid_ready", 128'(cmd_ready), 128'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 128'(cmd_ready), 128'd1);
        chk("rst_rel_depth", 128'(dut.mv_depth), 128'd1);
        chk("rst_rel_pj_depth", 128'(dut.pj_depth), 128'd1);
        tick();
        chk("rst_rel_data", data_out, 128'd0);
        chk("rst_rel_busy", 128'(busy), 128'd0);

        // LOAD_ID with valid held, followed by NOPs
        lid_cnt = 0;
        busy_seen = 1'b0;
        cmd_valid = 1'b1;
        cmd_op = 3'd2;
        tick();
        lid_cnt += int'(load_id_en);
        busy_seen |= busy;
        cmd_op = 3'd0;
        for (int k = 0; k < 5; k++) begin
            tick();
            lid_cnt += int'(load_id_en);
            busy_seen |= busy;
        end
        cmd_valid = 1'b0;
        chk("lid_pulses", 128'(lid_cnt), 128'd1);
        chk("lid_busy", 128'(busy_seen), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
